// File: rtl/pc_unit.sv
// ============================================================================
// Module      : pc_unit
// Description : Program-counter stage of a single-cycle MIPS datapath.
//               Computes the next fetch address, tracks RUN/HALT/FAULT state
//               and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] instr,
    input  logic [2:0]  npc_op,
    input  logic        zero,
    input  logic [31:0] rs_val,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        running,
    output logic        fault,
    output logic [31:0] retired
);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_HALT  = 2'd1;
    localparam logic [1:0] c_ST_FAULT = 2'd2;

    localparam logic [2:0] c_OP_BEQ = 3'd1;
    localparam logic [2:0] c_OP_BNE = 3'd2;
    localparam logic [2:0] c_OP_J   = 3'd3;
    localparam logic [2:0] c_OP_JR  = 3'd4;

    localparam logic [31:0] c_IM_BYTES = 32'(IM_WORDS * 4);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_retired;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_target;
    logic        w_illegal;
    logic        w_unused;

    // Opcode field is decoded upstream into npc_op.
    assign w_unused = &{1'b0, instr[31:26]};

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_target = w_pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        w_target = w_pc_plus4;
        case (npc_op)
            c_OP_BEQ: if (zero)  w_target = w_br_target;
            c_OP_BNE: if (!zero) w_target = w_br_target;
            c_OP_J:   w_target = {w_pc_plus4[31:28], instr[25:0], 2'b00};
            c_OP_JR:  w_target = rs_val;
            default:  w_target = w_pc_plus4;
        endcase
    end

    // The upper bound check also catches pc+4 running off the end of memory.
    assign w_illegal = (w_target[1:0] != 2'b00) || (w_target >= c_IM_BYTES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_RUN;
            r_pc      <= RESET_PC;
            r_retired <= 32'd0;
        end else if (en && (r_state == c_ST_RUN)) begin
            if (halt) begin
                r_state   <= c_ST_HALT;
                r_retired <= r_retired + 32'd1;
            end else if (w_illegal) begin
                r_state   <= c_ST_FAULT;
            end else begin
                r_pc      <= w_target;
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign running  = (r_state == c_ST_RUN);
    assign fault    = (r_state == c_ST_FAULT);
    assign retired  = r_retired;

endmodule

`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Program-counter stage of the single-cycle MIPS datapath. Holds the current PC and drives it as the fetch address into the 4 KiB instruction memory. Computes the next PC (sequential, BEQ/BNE, J/JAL, JR) from the fetched instruction and datapath flags. Supports stall, a halt state and a sticky fetch-fault state, and counts retired instructions.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IM_WORDS, 1024, instruction memory depth in words; legal fetch range is 0 .. IM_WORDS*4-4.

- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset; one clock, asynchronous, active-high.
- en  in  1  1 = advance; 0 = stall (all state holds).
- instr  in  32  instruction currently fetched at pc.
- npc_op  in  3  0 SEQ, 1 BEQ, 2 BNE, 3 J/JAL, 4 JR; 5-7 behave as SEQ.
- zero  in  1  ALU zero flag for the current instruction.
- rs_val  in  32  register rs value, JR target.
- halt  in  1  current instruction is a halt (end-of-program syscall).
- pc  out  32  current PC, drives instruction-memory addr.
- pc_plus4  out  32  pc + 4, link value for JAL.
- running  out  1  1 in RUN state.
- fault  out  1  1 in FAULT state (sticky).
- retired  out  32  count of instructions completed since reset.

## Operation

- States: RUN, HALT, FAULT. Reset enters RUN.
- pc_plus4 = pc + 4, modulo 2^32 (combinational).
- Target computation (combinational, all 32-bit, modulo 2^32):
  - SEQ: pc_plus4.
  - BEQ: pc_plus4 + (sign_extend(instr[15:0]) << 2) if zero=1, else pc_plus4.
  - BNE: same branch target if zero=0, else pc_plus4.
  - J/JAL: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - JR: rs_val.
- Target is illegal if target[1:0] != 0 or target >= IM_WORDS*4.
- RUN, en=1, evaluated in priority order:
  - halt=1: state -> HALT; pc holds; retired += 1.
  - target illegal: state -> FAULT; pc holds (points at faulting instruction); retired unchanged.
  - otherwise: pc <= target; retired += 1.
- RUN, en=0: nothing changes; halt and fault conditions ignored.
- HALT: pc, retired hold; only reset exits.
- FAULT: pc, retired hold; fault=1; only reset exits.
- retired wraps from 32'hFFFF_FFFF to 0.
- running = (state==RUN); fault = (state==FAULT); both registered-state decodes.

## Timing

- Reset (async assert, any time, including mid-stall or mid-branch): pc=RESET_PC, retired=0, state=RUN, running=1, fault=0 immediately; pc_plus4=RESET_PC+4.
- Deassertion synchronous to clk; first PC update on the first rising edge with rst=0 and en=1.
- Zero-latency next-PC: a redirect decided in cycle n appears on pc after the edge ending cycle n; no delay slot, no bubbles.
- pc, state, retired change only on rising clk (or async rst); pc_plus4 follows pc combinationally.
- halt and illegal target in the same cycle: HALT wins, fault stays 0.
- en=0 in the same cycle as halt or illegal target: no transition.
- pc + 4 from IM_WORDS*4-4 is illegal and enters FAULT (no wrap to 0).

## Test plan

- Reset/sequential: assert rst mid-run with pc=0x0000_0010 -> pc=0x0000_0000 immediately; 4 en=1 cycles of SEQ -> pc 0x4, 0x8, 0xC, 0x10, retired=4.
- Branches: pc=0x20, BEQ, instr[15:0]=16'hFFFE, zero=1 -> pc=0x1C; same with zero=0 -> pc=0x24; BNE, instr[15:0]=16'h0003, zero=0 -> pc=0x30.
- Jumps: pc=0x100, J, instr[25:0]=26'h000_0040 -> pc=0x100; JR, rs_val=0x0000_0FFC -> pc=0xFFC.
- Stall: en=0 for 3 cycles with npc_op=J and halt=1 -> pc, retired, state unchanged; en=1 then -> HALT.
- Faults: JR, rs_val=0x0000_0006 -> FAULT, pc holds, fault=1, retired unchanged; JR, rs_val=0x1000 -> FAULT; SEQ at pc=0xFFC -> FAULT; BEQ taken to 0x2000 with halt=1 -> HALT, fault=0.
- HALT/FAULT exit: after HALT, 10 cycles of SEQ with en=1 -> pc holds, running=0; rst -> RUN, pc=0, retired=0.
